// File: rtl/pc_stack_counter.sv
// pc_stack_counter: SAP program counter with jump, CALL/RET return stack, sticky stack errors and wrap pulse.
// State changes on the falling clock edge; clr is asynchronous, active-low.
module pc_stack_counter #(
  parameter int AW = 4,
  parameter int SD = 4,
  localparam int SPW = $clog2(SD + 1)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           cp,
  input  logic           ld,
  input  logic           call,
  input  logic           ret,
  input  logic           err_clr,
  input  logic [AW-1:0]  din,
  input  logic           en,
  output logic [AW-1:0]  bus_out,
  output logic [AW-1:0]  pc_q,
  output logic [SPW-1:0] depth,
  output logic           ovf,
  output logic           unf,
  output logic           wrap
);
  logic [AW-1:0]  r_pc, w_pc_n, w_top;
  logic [SPW-1:0] r_depth, w_depth_n;
  logic           r_ovf, r_unf, r_wrap, w_ovf_n, w_unf_n, w_wrap_n;
  logic           w_empty, w_full, w_push;
  logic [AW-1:0]  r_stack [SD];

  assign w_empty = r_depth == '0;
  assign w_full  = r_depth == SPW'(SD);
  assign w_push  = !ret && call && !w_full;

  // depth is the only pointer: the top entry lives at index depth-1
  always_comb begin
    w_top = '0;
    for (int i = 0; i < SD; i++)
      if (r_depth == SPW'(i + 1)) w_top = r_stack[i];
  end

  always_comb begin
    w_pc_n    = r_pc;
    w_depth_n = r_depth;
    w_wrap_n  = 1'b0;
    w_ovf_n   = r_ovf & ~err_clr;
    w_unf_n   = r_unf & ~err_clr;
    if (ret) begin
      w_pc_n    = w_empty ? r_pc : w_top;
      w_depth_n = w_empty ? r_depth : r_depth - 1'b1;
      w_unf_n   = w_unf_n | w_empty;
    end else if (call) begin
      w_pc_n    = w_full ? r_pc : din;
      w_depth_n = w_full ? r_depth : r_depth + 1'b1;
      w_ovf_n   = w_ovf_n | w_full;
    end else if (ld) begin
      w_pc_n = din;
    end else if (cp) begin
      w_pc_n   = r_pc + 1'b1;
      w_wrap_n = &r_pc;
    end
  end

  always_ff @(negedge clk or negedge clr)
    if (!clr) begin
      r_pc    <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_pc    <= w_pc_n;
      r_depth <= w_depth_n;
      r_ovf   <= w_ovf_n;
      r_unf   <= w_unf_n;
      r_wrap  <= w_wrap_n;
    end

  always_ff @(negedge clk)
    for (int i = 0; i < SD; i++)
      if (w_push && r_depth == SPW'(i)) r_stack[i] <= r_pc;

  assign bus_out = en ? r_pc : {AW{1'bz}};
  assign pc_q    = r_pc;
  assign depth   = r_depth;
  assign ovf     = r_ovf;
  assign unf     = r_unf;
  assign wrap    = r_wrap;
endmodule

// File: doc/pc_stack_counter.md
Name: pc_stack_counter

Overview:
- Parametrised SAP-family program counter for the next processor revision.
- Adds jump load, CALL/RET through an internal return-address stack, sticky stack-error flags and a wrap indication to the basic increment/clear counter.
- Drives the shared W-bus through a tri-state output and exposes a permanently-driven copy of the count for the controller and debug.
- State updates on the falling clock edge, matching the SAP controller timing (control lines settle on the rising edge).

Parameters:
- AW, 4, address width in bits (AW >= 2).
- SD, 4, return-stack depth in entries (SD >= 1).
- SPW, $clog2(SD+1), stack-occupancy width, derived; not overridden.

Ports:
- clk  input  1  system clock; all state changes on the falling edge.
- clr  input  1  reset, asynchronous, active-low.
- cp  input  1  count enable: PC <= PC+1.
- ld  input  1  jump: PC <= din.
- call  input  1  push PC onto the stack, then PC <= din.
- ret  input  1  PC <= top of stack, pop.
- err_clr  input  1  synchronous clear of ovf/unf.
- din  input  AW  jump/call target.
- en  input  1  drive bus_out.
- bus_out  output  AW  PC when en=1, else all-Z.
- pc_q  output  AW  registered PC, always driven.
- depth  output  SPW  number of valid stack entries.
- ovf  output  1  sticky: call attempted with the stack full.
- unf  output  1  sticky: ret attempted with the stack empty.
- wrap  output  1  one-cycle pulse: the cp increment wrapped from all-ones to 0.

Behaviour:
- clr=0 (asynchronous, overrides everything):
  - PC=0, depth=0, ovf=0, unf=0, wrap=0.
  - Stack contents are don't-care.
  - bus_out still follows en, so it shows 0 if en=1.
- Each falling edge with clr=1 executes exactly one operation. Priority is ret > call > ld > cp; lower-priority requests in the same cycle are ignored. Cases:
  - ret, depth>0: PC <= stack[depth-1]; depth <= depth-1.
  - ret, depth=0: PC unchanged; depth unchanged; unf <= 1.
  - call, depth<SD: stack[depth] <= PC (current value, i.e. the return address, since fetch has already incremented); depth <= depth+1; PC <= din.
  - call, depth=SD: no push; PC unchanged; ovf <= 1.
  - ld: PC <= din; stack untouched.
  - cp: PC <= PC+1, modulo 2^AW.
  - none: hold.
- wrap is registered. It is 1 for exactly the cycle following a cp increment from 2^AW-1 to 0, and 0 otherwise, including when ld or call lands on 0.
- Error flags:
  - ovf/unf stay set until err_clr or clr.
  - err_clr clears both flags on the edge.
  - If err_clr and a new error occur on the same edge, the new error wins and the flag is 1.
- Stack organisation:
  - LIFO; entries are AW bits.
  - The stack is a register array indexed by depth, with no separate pointer, so depth is the single source of truth.
- Outputs:
  - bus_out = en ? PC : 'z. Purely combinational from the registered PC; no latency on en.
  - pc_q, depth, ovf, unf and wrap are all registered, with zero combinational path from the control inputs.
- Latency: every operation is visible on pc_q immediately after the falling edge on which it was sampled.
- Controller rule (not enforced by this block): assert at most one of ret/call/ld/cp per cycle. Priority only defines the result if this rule is violated.

Test Plan (AW=4, SD=2 unless stated):
1. Reset/count:
   - Stimulus: pulse clr low mid-cycle with cp=1, then 17 cp edges.
   - Required: PC=0 immediately on clr, with no clock needed. After the 17 edges PC=1. wrap=1 only in the cycle after the 15->0 step.
2. Jump and tri-state:
   - Stimulus: PC=3, ld=1, din=0xA; then toggle en.
   - Required: PC=0xA. bus_out=0xA when en=1 and ZZZZ when en=0. pc_q=0xA throughout.
3. Nested call/return:
   - Stimulus: PC=5, call din=0x8; cp; call din=0xC; ret; ret.
   - Required: PC sequence 8, 9, C, 9, 5. depth sequence 1, 1, 2, 1, 0. No flags set.
4. Overflow/underflow:
   - Stimulus: two calls to reach depth=2, a third call din=0xF, then three rets.
   - Required: the third call leaves PC unchanged and sets ovf=1. The rets return correctly twice; the third ret leaves PC unchanged, sets unf=1 and keeps depth=0.
   - Then: err_clr=1 clears both flags. err_clr together with ret at depth=0 leaves unf=1.
5. Priority:
   - Stimulus: depth=1 with top entry 0x2; assert ret, call, ld and cp together with din=0x7.
   - Required: PC=0x2 and depth=0; the call, ld and cp requests are ignored.
   - Then: call+ld+cp together with din=0x7 gives PC=0x7, depth=1, and the stack top equals the old PC.
6. Reset mid-stack:
   - Stimulus: depth=2, assert clr; after release, ret.
   - Required: depth=0 and PC=0 on clr. The following ret sets unf=1 and leaves PC=0.
   - Also: repeat scenario 3 with AW=8, SD=4 and push four levels.
